// File: rtl/uart_tx_frame_if.sv
// Parallel-side handshake and serial-side outputs of the UART transmit serializer.
// The master (TX FIFO / register block) drives the request; the slave returns line and busy.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_data_valid;
  logic                  i_par_en;
  logic                  i_par_typ;
  logic                  o_tx;
  logic                  o_busy;

  modport master (
    output i_data, i_data_valid, i_par_en, i_par_typ,
    input  o_tx, o_busy
  );

  modport slave (
    input  i_data, i_data_valid, i_par_en, i_par_typ,
    output o_tx, o_busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit(s).
// Optional parity support is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_frame #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  uart_tx_frame_if.slave bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  baud_end_s;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] word, input logic odd);
    return odd ? ~^word : ^word;
  endfunction
`else
  logic unused_par_s;
  assign unused_par_s = bus.i_par_en ^ bus.i_par_typ;
`endif

  assign baud_end_s = (baud_q == BAUD_LAST);
  assign bus.o_tx   = tx_q;
  assign bus.o_busy = busy_q;

  // State, counters, shadow word and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  // Next-state: every non-idle state lasts whole bit periods.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_data_valid) state_d = ST_START;
        else                  state_d = ST_IDLE;
      end
      ST_START: begin
        if (baud_end_s) state_d = ST_DATA;
        else            state_d = ST_START;
      end
      ST_DATA: begin
        if (baud_end_s && (bit_q == BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
          if (par_en_q) state_d = ST_PARITY;
          else          state_d = ST_STOP;
`else
          state_d = ST_STOP;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_end_s) state_d = ST_STOP;
        else            state_d = ST_PARITY;
      end
`endif
      ST_STOP: begin
        if (baud_end_s && (bit_q == STOP_LAST)) state_d = ST_IDLE;
        else                                    state_d = ST_STOP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath: the line value for the next bit is loaded on each bit boundary.
  always_comb begin
    baud_d    = baud_end_s ? '0 : baud_q + BAUD_W'(1);
    bit_d     = bit_q;
    data_d    = data_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (bus.i_data_valid) begin
          data_d    = bus.i_data;
`ifdef UART_TX_PARITY_EN
          par_en_d  = bus.i_par_en;
          par_bit_d = parity_bit(bus.i_data, bus.i_par_typ);
`endif
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end else begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
        end
      end
      ST_START: begin
        if (baud_end_s) begin
          bit_d = '0;
          tx_d  = data_q[0];
        end else begin
          tx_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (baud_end_s && (bit_q == BIT_LAST)) begin
          bit_d = '0;
`ifdef UART_TX_PARITY_EN
          tx_d  = par_en_q ? par_bit_q : 1'b1;
`else
          tx_d  = 1'b1;
`endif
        end else if (baud_end_s) begin
          // Shift so the next bit to send always sits at bit 1 of the shadow word.
          bit_d  = bit_q + BIT_W'(1);
          data_d = data_q >> 1;
          tx_d   = data_q[1];
        end else begin
          tx_d = tx_q;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_end_s) begin
          bit_d = '0;
          tx_d  = 1'b1;
        end else begin
          tx_d = tx_q;
        end
      end
`endif
      ST_STOP: begin
        tx_d = 1'b1;
        if (baud_end_s && (bit_q == STOP_LAST)) begin
          bit_d  = '0;
          busy_d = 1'b0;
        end else if (baud_end_s) begin
          bit_d = bit_q + BIT_W'(1);
        end else begin
          bit_d = bit_q;
        end
      end
      default: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: one-stop-bit and two-stop-bit instances,
// table-driven frames, hand-written corner sequences and randomized frames.
module tb_uart_tx_frame;

  localparam int DW = 8;
  localparam int C  = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  typedef struct {
    bit          sel;
    logic [7:0]  data;
    bit          pe;
    bit          pt;
    int          len_par;
    int          len_nopar;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_WIDTH(DW)) if_a ();
  uart_tx_frame_if #(.DATA_WIDTH(DW)) if_b ();

  uart_tx_frame #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C), .STOP_BITS(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if_a)
  );
  uart_tx_frame #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C), .STOP_BITS(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a frame is a list of bit values, each held C cycles.
  function automatic int frame_len(input bit sel, input bit pe);
    return (1 + DW + ((pe && PAR_BUILT) ? 1 : 0) + (sel ? 2 : 1)) * C;
  endfunction

  function automatic logic exp_bit(input logic [7:0] d, input bit pe, input bit pt, input int k);
    int idx;
    idx = k / C;
    if (idx == 0) return 1'b0;
    if (idx <= DW) return d[idx-1];
    if (pe && PAR_BUILT && idx == DW + 1) return logic'((($countones(d) % 2) != 0) ^ pt);
    return 1'b1;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [7:0] d, input logic pe, input logic pt);
    if (sel) begin
      if_b.i_data_valid = v; if_b.i_data = d; if_b.i_par_en = pe; if_b.i_par_typ = pt;
    end else begin
      if_a.i_data_valid = v; if_a.i_data = d; if_a.i_par_en = pe; if_a.i_par_typ = pt;
    end
  endtask

  function automatic logic get_tx(input bit sel);
    return sel ? if_b.o_tx : if_a.o_tx;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? if_b.o_busy : if_a.o_busy;
  endfunction

  // Entered at a negedge; leaves at the negedge following the accept edge.
  task automatic start_frame(input bit sel, input logic [7:0] d, input bit pe, input bit pt, input bit hold);
    drive(sel, 1'b1, d, pe, pt);
    @(posedge clk);
    @(negedge clk);
    if (!hold) drive(sel, 1'b0, d, pe, pt);
  endtask

  task automatic check_frame(input bit sel, input logic [7:0] d, input bit pe, input bit pt,
                             input int pulse_at, input int upto, input string tag,
                             output int busy_cnt);
    int len, lim;
    len = frame_len(sel, pe);
    lim = (upto < 0) ? len : upto;
    busy_cnt = 0;
    for (int k = 0; k < lim; k++) begin
      chk({tag, " tx"}, {31'd0, get_tx(sel)}, {31'd0, exp_bit(d, pe, pt, k)});
      chk({tag, " busy"}, {31'd0, get_busy(sel)}, 32'd1);
      if (get_busy(sel) === 1'b1) busy_cnt++;
      if (pulse_at >= 0 && k == pulse_at) drive(sel, 1'b1, 8'h00, ~pe, ~pt);
      else if (pulse_at >= 0 && k == pulse_at + 1) drive(sel, 1'b0, 8'h00, pe, pt);
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input bit sel, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk({tag, " idle tx"}, {31'd0, get_tx(sel)}, 32'd1);
      chk({tag, " idle busy"}, {31'd0, get_busy(sel)}, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   bc;
    bit   sel, pe, pt;
    logic [7:0] d;

    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 40, 40};
    vecs[1] = '{1'b0, 8'hA5, 1'b1, 1'b0, 44, 40};
    vecs[2] = '{1'b0, 8'hA5, 1'b1, 1'b1, 44, 40};
    vecs[3] = '{1'b1, 8'h81, 1'b0, 1'b0, 44, 44};
    vecs[4] = '{1'b1, 8'h81, 1'b1, 1'b0, 48, 44};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 44, 40};
    vecs[6] = '{1'b0, 8'hFF, 1'b0, 1'b1, 40, 40};

    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset tx a", {31'd0, if_a.o_tx}, 32'd1);
    chk("reset busy a", {31'd0, if_a.o_busy}, 32'd0);
    chk("reset tx b", {31'd0, if_b.o_tx}, 32'd1);
    chk("reset busy b", {31'd0, if_b.o_busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(1'b0, 2, "post reset a");
    check_idle(1'b1, 1, "post reset b");

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      start_frame(vecs[i].sel, vecs[i].data, vecs[i].pe, vecs[i].pt, 1'b0);
      check_frame(vecs[i].sel, vecs[i].data, vecs[i].pe, vecs[i].pt, -1, -1, $sformatf("vec%0d", i), bc);
      chk($sformatf("vec%0d busy length", i), bc, PAR_BUILT ? vecs[i].len_par : vecs[i].len_nopar);
      check_idle(vecs[i].sel, 2, $sformatf("vec%0d", i));
    end

    // Request held high, data changed mid-frame, back-to-back second frame
    start_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    check_frame(1'b0, 8'h3C, 1'b0, 1'b0, -1, -1, "b2b first", bc);
    chk("b2b gap tx", {31'd0, if_a.o_tx}, 32'd1);
    chk("b2b gap busy", {31'd0, if_a.o_busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    check_frame(1'b0, 8'hFF, 1'b0, 1'b0, -1, -1, "b2b second", bc);
    check_idle(1'b0, 3, "b2b end");

    // Request pulse while busy is ignored and not queued
    start_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    check_frame(1'b0, 8'h5A, 1'b0, 1'b0, 8, -1, "busy pulse", bc);
    check_idle(1'b0, 6, "busy pulse");

    // Reset during data bit 3 aborts the frame at once
    start_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b0);
    check_frame(1'b0, 8'hC3, 1'b0, 1'b0, -1, 17, "abort", bc);
    rst_n = 1'b0;
    #1;
    chk("abort tx", {31'd0, if_a.o_tx}, 32'd1);
    chk("abort busy", {31'd0, if_a.o_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(1'b0, 6, "after abort");

    // Randomized frames with random gaps and stray requests
    for (int i = 0; i < 30; i++) begin
      sel = 1'($urandom_range(0, 1));
      d   = 8'($urandom_range(0, 255));
      pe  = 1'($urandom_range(0, 1));
      pt  = 1'($urandom_range(0, 1));
      start_frame(sel, d, pe, pt, 1'b0);
      check_frame(sel, d, pe, pt, ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 30)) : -1,
                  -1, $sformatf("rand%0d", i), bc);
      chk($sformatf("rand%0d busy length", i), bc, frame_len(sel, pe));
      check_idle(sel, 1 + int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmit serializer, the transmit-side counterpart of the UART_RX datapath.
- Accepts one parallel data word per frame via a valid/busy handshake.
- Emits start bit, data bits LSB-first, optional parity bit, then stop bit(s) on o_tx.
- Bit timing comes from an internal baud counter: each bit lasts CLKS_PER_BIT i_clk cycles.
- Sits between the TX register interface/FIFO and the serial pad.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9).
CLKS_PER_BIT, 16, i_clk cycles per serial bit (>=2).
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset; asynchronous, active-low
i_data  input  DATA_WIDTH  word to transmit
i_data_valid  input  1  request to start a frame with i_data
i_par_en  input  1  1 = insert parity bit
i_par_typ  input  1  0 = even parity, 1 = odd parity
o_tx  output  1  serial line, idle high
o_busy  output  1  frame in progress; requests are ignored while high

Behaviour:
- Reset: i_clk and i_rst_n as above; reset is asynchronous and active-low.
  - o_tx=1, o_busy=0, state=IDLE, all counters 0.
  - Reset asserted mid-frame aborts the frame immediately; o_tx returns to 1 with no partial stop bit.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_tx=1, o_busy=0.
  - On an edge with i_data_valid=1: latch i_data, i_par_en and i_par_typ into a shadow register; go to START.
  - On that same edge: o_tx<=0, o_busy<=1. Latency from accept to the line falling is 1 cycle.
- START: hold o_tx=0 for CLKS_PER_BIT cycles, then go to DATA. o_tx takes bit 0 on the transition edge.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles; the bit counter increments on each bit boundary.
  - After bit DATA_WIDTH-1: go to PARITY if the latched par_en=1, else go to STOP.
- PARITY:
  - Parity bit = ^data when par_typ=0; ~^data when par_typ=1.
  - Computed from the latched word and held CLKS_PER_BIT cycles. Then go to STOP.
- STOP:
  - o_tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final cycle's edge: go to IDLE and set o_busy<=0.
- Baud counter:
  - Runs 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Cleared in IDLE; never free-running.
- Bit counter: width $clog2(DATA_WIDTH); cleared on entry to DATA.
- Frame length, accept edge to o_busy falling: (1+DATA_WIDTH+P+STOP_BITS)*CLKS_PER_BIT cycles, with P = latched par_en.
- Requests while busy:
  - i_data_valid while o_busy=1 is ignored (not queued).
  - Changes on i_data, i_par_en or i_par_typ mid-frame have no effect.
- Back-to-back frames:
  - A request on the first IDLE cycle after o_busy falls is accepted.
  - The minimum idle-high gap between frames is therefore 1 i_clk cycle beyond the stop bit(s).

Optional Feature:
UART_TX_PARITY_EN
- Defined: PARITY state and parity logic are present, as described above.
- Undefined:
  - PARITY state and parity logic are removed.
  - i_par_en and i_par_typ remain as ports but are ignored.
  - Frames never carry a parity bit; frame length is (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT.

Test Plan:
1. CLKS_PER_BIT=4, DATA_WIDTH=8, STOP_BITS=1, par_en=0; send 0xA5.
   -> o_tx in 4-cycle bits: 0,1,0,1,0,0,1,0,1,1.
   -> o_busy high exactly 40 cycles; o_tx falls 1 cycle after the accept edge.
2. Same config, par_en=1, send 0xA5.
   -> par_typ=0: parity bit 0; par_typ=1: parity bit 1.
   -> Frame is 44 cycles.
3. Hold i_data_valid=1 with 0x3C, then change i_data to 0xFF mid-frame.
   -> First frame carries 0x3C.
   -> Second frame (0xFF) starts 1 cycle after o_busy falls, with o_tx=1 for that gap cycle.
4. Pulse i_data_valid with 0x00 while o_busy=1.
   -> No effect on the current frame and no extra frame.
5. Assert i_rst_n=0 during data bit 3.
   -> o_tx=1 and o_busy=0 immediately.
   -> After release, line stays idle until a new request.
6. STOP_BITS=2, send 0x81.
   -> Stop high for 8 cycles; total frame 44 cycles.
   -> Without UART_TX_PARITY_EN, par_en=1 still yields a 44-cycle frame with no parity bit.
